// File: rtl/conv_encoder.sv
`default_nettype none
// ============================================================================
// Module      : conv_encoder
// Description : Rate-1/2, K=4 (8-state) convolutional encoder with a
//               valid/ready stream interface and 3-symbol zero tail per frame.
//               Generators g0=1111 -> d_out[1], g1=1101 -> d_out[0].
//               Shift register sr: sr[2] newest bit, sr[0] oldest.
//
// Parameters  : FRAME_LEN   information bits per frame (4..1024), no tail
//
// Ports       : clk          rising-edge clock
//               rst          synchronous active-high reset (beats enable)
//               enable       0 forces IDLE and clears the block next cycle
//               in_valid     in_bit is valid
//               in_bit       information bit
//               in_ready     encoder takes in_bit this cycle
//               out_valid    d_out holds a valid symbol
//               out_ready    sink consumes the symbol this cycle
//               d_out        code symbol {g0, g1}
//               frame_first  d_out is the first symbol of a frame
//               frame_last   d_out is the last tail symbol of a frame
//               err_en       (CONV_ENC_ERR_INJECT_EN only) corrupt this symbol
//               err_mask     (CONV_ENC_ERR_INJECT_EN only) XOR mask for d_out
//
// Options     : define CONV_ENC_ERR_INJECT_EN to add the error-injection
//               ports; the mask touches only the loaded symbol, never sr.
//
// Revision    : 1.0  initial release
// ============================================================================
module conv_encoder #(
  parameter int FRAME_LEN = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] d_out,
  output logic       frame_first,
  output logic       frame_last
`ifdef CONV_ENC_ERR_INJECT_EN
  ,
  input  logic       err_en,
  input  logic [1:0] err_mask
`endif
);

  localparam logic [9:0] c_last_bit  = 10'(FRAME_LEN - 1);
  localparam logic [1:0] c_last_tail = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_TAIL = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next_state;

  logic [2:0] r_sr;
  logic [9:0] r_bit_cnt;
  logic [1:0] r_tail_cnt;
  logic       r_out_valid;
  logic [1:0] r_d_out;
  logic       r_frame_first;
  logic       r_frame_last;

  logic       w_slot_free;
  logic       w_in_ready;
  logic       w_accept;
  logic       w_tail_gen;
  logic       w_gen;
  logic       w_u;
  logic [1:0] w_sym;
  logic [1:0] w_load;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and handshake decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_accept     = 1'b0;
    w_tail_gen   = 1'b0;
    // The output register can take a new symbol when empty or being drained.
    w_slot_free  = !r_out_valid || out_ready;

    case (r_state)
      S_IDLE: begin
        w_next_state = S_DATA;
      end
      S_DATA: begin
        w_in_ready = w_slot_free;
        w_accept   = in_valid && w_slot_free;
        if (w_accept && (r_bit_cnt == c_last_bit)) begin
          w_next_state = S_TAIL;
        end
      end
      S_TAIL: begin
        w_tail_gen = w_slot_free;
        if (w_tail_gen && (r_tail_cnt == c_last_tail)) begin
          w_next_state = S_DATA;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase

    if (!enable) begin
      w_next_state = S_IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // Symbol computation. Tail symbols flush the register with u=0.
  // --------------------------------------------------------------------------
  always_comb begin
    w_gen = w_accept || w_tail_gen;
    w_u   = w_accept && in_bit;
    w_sym = {w_u ^ r_sr[2] ^ r_sr[1] ^ r_sr[0],
             w_u ^ r_sr[2] ^ r_sr[0]};
`ifdef CONV_ENC_ERR_INJECT_EN
    w_load = err_en ? (w_sym ^ err_mask) : w_sym;
`else
    w_load = w_sym;
`endif
  end

  // --------------------------------------------------------------------------
  // Datapath: shift register, counters and output register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_sr          <= 3'b000;
      r_bit_cnt     <= 10'd0;
      r_tail_cnt    <= 2'd0;
      r_out_valid   <= 1'b0;
      r_d_out       <= 2'b00;
      r_frame_first <= 1'b0;
      r_frame_last  <= 1'b0;
    end else begin
      if (w_gen) begin
        r_sr          <= {w_u, r_sr[2:1]};
        r_d_out       <= w_load;
        r_out_valid   <= 1'b1;
        r_frame_first <= w_accept && (r_bit_cnt == 10'd0);
        r_frame_last  <= w_tail_gen && (r_tail_cnt == c_last_tail);
      end else if (r_out_valid && out_ready) begin
        r_out_valid   <= 1'b0;
        r_frame_first <= 1'b0;
        r_frame_last  <= 1'b0;
      end

      if (w_accept) begin
        r_bit_cnt <= (r_bit_cnt == c_last_bit) ? 10'd0 : r_bit_cnt + 10'd1;
      end

      if (w_tail_gen) begin
        if (r_tail_cnt == c_last_tail) begin
          r_tail_cnt <= 2'd0;
          // Three zero shifts already flush sr; forcing it keeps the next
          // frame start explicit.
          r_sr       <= 3'b000;
        end else begin
          r_tail_cnt <= r_tail_cnt + 2'd1;
        end
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign d_out       = r_d_out;
  assign frame_first = r_frame_first;
  assign frame_last  = r_frame_last;

endmodule
`default_nettype wire

// File: tb/tb_conv_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_encoder
// Description : Self-checking bench for conv_encoder. A behavioural model
//               computes each code symbol as a convolution of the frame's
//               input history with the generator taps and tracks the
//               frame phase and output-register occupancy.
// Revision    : 1.0  initial release
// ============================================================================
module tb_conv_encoder;

  localparam int FL = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       in_valid;
  logic       in_bit;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] d_out;
  logic       frame_first;
  logic       frame_last;
`ifdef CONV_ENC_ERR_INJECT_EN
  logic       err_en;
  logic [1:0] err_mask;
`endif

  always #5 clk = ~clk;

  conv_encoder #(.FRAME_LEN(FL)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .d_out       (d_out),
    .frame_first (frame_first),
    .frame_last  (frame_last)
`ifdef CONV_ENC_ERR_INJECT_EN
    ,
    .err_en      (err_en),
    .err_mask    (err_mask)
`endif
  );

  int         n_checks = 0;
  int         n_fail   = 0;

  // Reference model: 0=idle, 1=data, 2=tail
  int         m_phase  = 0;
  int         m_ntail  = 0;
  bit         m_ev     = 1'b0;
  bit         m_ef     = 1'b0;
  bit         m_el     = 1'b0;
  logic [1:0] m_sym    = 2'b00;
  bit         m_fb[$];
  logic [1:0] obs[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Symbol k of the frame: XOR of the generator-tapped input history.
  function automatic logic [1:0] conv(input int k);
    bit g0 = 1'b0;
    bit g1 = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (k - j >= 0) begin
        g0 = g0 ^ m_fb[k - j];
        if (j != 2) g1 = g1 ^ m_fb[k - j];
      end
    end
    return {g0, g1};
  endfunction

  task automatic model_clear();
    m_phase = 0;
    m_ntail = 0;
    m_ev    = 1'b0;
    m_ef    = 1'b0;
    m_el    = 1'b0;
    m_sym   = 2'b00;
    m_fb.delete();
  endtask

  // One clock cycle: drive inputs, check the DUT, advance the model.
  task automatic cyc(input bit v, input bit b, input bit ordy, input bit en,
                     input bit r, input bit ee, output bit acc);
    bit eir;
    bit slot;
    bit gen;
    bit u;
    bit tailp;
    int k;
    logic [1:0] s;
    @(negedge clk);
    rst       = r;
    enable    = en;
    in_valid  = v;
    in_bit    = b;
    out_ready = ordy;
`ifdef CONV_ENC_ERR_INJECT_EN
    err_en    = ee;
`endif
    #1;
    eir = (m_phase == 1) && (!m_ev || ordy);
    check("in_ready", in_ready, eir);
    check("out_valid", out_valid, m_ev);
    if (m_ev) begin
      check("d_out", d_out, m_sym);
      check("frame_first", frame_first, m_ef);
      check("frame_last", frame_last, m_el);
    end
    if (out_valid && out_ready) obs.push_back(d_out);
    acc = v && eir && !r && en;

    if (r || !en) begin
      model_clear();
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else begin
      slot  = !m_ev || ordy;
      tailp = (m_phase == 2);
      gen   = 1'b0;
      u     = 1'b0;
      if (!tailp && v && slot) begin
        gen = 1'b1;
        u   = b;
      end else if (tailp && slot) begin
        gen = 1'b1;
      end
      if (gen) begin
        m_fb.push_back(u);
        k = m_fb.size() - 1;
        s = conv(k);
`ifdef CONV_ENC_ERR_INJECT_EN
        if (ee) s = s ^ 2'b01;
`endif
        m_sym = s;
        m_ev  = 1'b1;
        m_ef  = !tailp && (k == 0);
        m_el  = tailp && (m_ntail == 2);
        if (!tailp && k == FL - 1) begin
          m_phase = 2;
          m_ntail = 0;
        end else if (tailp) begin
          m_ntail++;
          if (m_ntail == 3) begin
            m_phase = 1;
            m_ntail = 0;
            m_fb.delete();
          end
        end
      end else if (m_ev && ordy) begin
        m_ev = 1'b0;
        m_ef = 1'b0;
        m_el = 1'b0;
      end
    end
  endtask

  // Sends one frame (bits[0] first) with the sink always ready.
  task automatic send_frame(input logic [3:0] bits, input int ee_idx, input int ncyc);
    int i = 0;
    bit acc;
    obs.delete();
    repeat (ncyc) begin
      cyc(i < 4, (i < 4) ? bits[i[1:0]] : 1'b0, 1'b1, 1'b1, 1'b0, (i == ee_idx), acc);
      if (acc) i++;
    end
    check("frame_bits_sent", i, 4);
  endtask

  // Expected sequence packed with the first symbol in the top bits.
  task automatic compare_obs(input string tag, input logic [13:0] exp);
    check({tag, "_count"}, obs.size(), 7);
    for (int j = 0; j < 7; j++) begin
      if (j < obs.size()) check(tag, obs[j], exp[13 - 2*j -: 2]);
    end
  endtask

  task automatic check_cleared(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_d_out"}, d_out, 2'b00);
    check({tag, "_first"}, frame_first, 1'b0);
    check({tag, "_last"}, frame_last, 1'b0);
  endtask

  initial begin
    bit acc;
    rst       = 1'b1;
    enable    = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b1;
`ifdef CONV_ENC_ERR_INJECT_EN
    err_en    = 1'b0;
    err_mask  = 2'b01;
`endif

    // Reset with enable high: reset wins
    cyc(1, 1, 1, 1, 1, 0, acc);
    cyc(1, 1, 1, 1, 1, 0, acc);
    check_cleared("reset");

    // Impulse and all-ones frames
    send_frame(4'b0001, -1, 12);
    compare_obs("impulse", 14'b11_11_10_11_00_00_00);
    send_frame(4'b1111, -1, 10);
    compare_obs("all_ones", 14'b11_00_10_01_10_01_11);

    // Backpressure: sink stalls 5 cycles mid-frame
    for (int c = 0; c < 20; c++) begin
      cyc(1, 1'($urandom), !(c >= 4 && c < 9), 1, 0, 0, acc);
    end
    repeat (8) cyc(0, 0, 1, 1, 0, 0, acc);

    // Randomized traffic with occasional enable drops and resets
    for (int c = 0; c < 3000; c++) begin
      cyc($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 9) < 7,
          $urandom_range(0, 99) != 0, $urandom_range(0, 199) == 0, 0, acc);
    end
    repeat (8) cyc(0, 0, 1, 1, 0, 0, acc);

    // Reset mid-frame, then a clean impulse frame
    cyc(1, 1, 1, 1, 0, 0, acc);
    cyc(1, 1, 1, 1, 0, 0, acc);
    cyc(1, 0, 1, 1, 0, 0, acc);
    cyc(1, 1, 1, 1, 1, 0, acc);
    check_cleared("mid_rst");
    send_frame(4'b0001, -1, 12);
    compare_obs("impulse_after_rst", 14'b11_11_10_11_00_00_00);

    // Enable dropped for one cycle during the tail
    for (int c = 0; c < 5; c++) cyc(1, 1, 1, 1, 0, 0, acc);
    cyc(0, 0, 1, 0, 0, 0, acc);
    check_cleared("en_drop");
    send_frame(4'b0001, -1, 12);
    compare_obs("impulse_after_en", 14'b11_11_10_11_00_00_00);

`ifdef CONV_ENC_ERR_INJECT_EN
    // Corrupt only the second symbol of the impulse frame
    send_frame(4'b0001, 1, 10);
    compare_obs("err_inject", 14'b11_10_10_11_00_00_00);
`endif

    repeat (4) cyc(0, 0, 1, 1, 0, 0, acc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
